// File: rtl/mod_div_sched.sv
// rtl/mod_div_sched.sv - round-robin scheduler around one shared repeated-subtraction divider
// Optional MOD_DIV_CYCCNT_EN adds the CYCLES port reporting SUB cycles of the last operation.
module mod_div_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] x_a,
  input  logic [WIDTH-1:0] y_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] x_b,
  input  logic [WIDTH-1:0] y_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div0
`ifdef MOD_DIV_CYCCNT_EN
  ,
  output logic [WIDTH-1:0] cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] yreg;
  logic [WIDTH-1:0] diff;
  logic             owner;   // 0 = A, 1 = B
  logic             last;    // requester granted most recently, 0 = A, 1 = B
  logic             pick_b;
  logic             grant;
  logic             can_sub;

  // B wins when it is the only requester or when A was served last
  assign pick_b  = req_b & (~req_a | ~last);
  assign grant   = gnt_a | gnt_b;
  assign diff    = r + ~yreg + WIDTH'(1);
  assign can_sub = (r >= yreg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    done_a     = 1'b0;
    done_b     = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!reset && (req_a || req_b)) begin
          gnt_b      = pick_b;
          gnt_a      = ~pick_b;
          state_next = S_SUB;
        end
      end
      S_SUB: begin
        busy = 1'b1;
        if (div0 || !can_sub) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done_a     = ~owner;
        done_b     = owner;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      r     <= '0;
      yreg  <= '0;
      div0  <= 1'b0;
      owner <= 1'b0;
      last  <= 1'b1;
    end else if (grant) begin
      r     <= pick_b ? x_b : x_a;
      yreg  <= pick_b ? y_b : y_a;
      div0  <= pick_b ? (y_b == '0) : (y_a == '0);
      q     <= '0;
      owner <= pick_b;
      last  <= pick_b;
    end else if (state == S_SUB) begin
      if (div0) begin
        q <= '1;
      end else if (can_sub) begin
        r <= diff;
        q <= q + WIDTH'(1);
      end
    end
  end

`ifdef MOD_DIV_CYCCNT_EN
  // Counts every SUB cycle including the final compare; holds until the next grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else if (grant) begin
      cycles <= '0;
    end else if (state == S_SUB && cycles != '1) begin
      cycles <= cycles + WIDTH'(1);
    end
  end
`endif

endmodule
